mux_scan_reg: RTL

//   Registered, parametrised N:1 multiplexer; successor to the 2:1 combinational mux.

---
 rtl/mux_scan_reg.sv | 112 +++++++++++
 1 files changed

// File: rtl/mux_scan_reg.sv
// ============================================================================
// Module      : mux_scan_reg
// Description : Registered N:1 multiplexer with a channel tag on its output.
//               The channel comes from the manual select input, or from an
//               internal round-robin scanner that stays on each channel for
//               DWELL enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_reg #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               MODE,
    input  logic [SELW-1:0]    SEL_IN,
    input  logic [N*WIDTH-1:0] D,
    output logic [WIDTH-1:0]   Y,
    output logic [SELW-1:0]    CH,
    output logic               VALID,
    output logic               WRAP
);

    localparam int              CNTW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int              NSLOT      = 1 << SELW;
    localparam logic [SELW:0]   c_N_EXT    = (SELW+1)'(N);
    localparam logic [SELW-1:0] c_LAST     = SELW'(N - 1);
    localparam logic [CNTW-1:0] c_CNT_LAST = CNTW'(DWELL - 1);

    // Channel array is sized to the full select range so any select value
    // indexes a defined slot; slots beyond N-1 read as zero.
    logic [WIDTH-1:0] w_ch [NSLOT];

    logic [WIDTH-1:0] r_y;
    logic [SELW-1:0]  r_ch;
    logic             r_valid;
    logic             r_wrap;
    logic [SELW-1:0]  r_ptr;
    logic [CNTW-1:0]  r_cnt;

    logic             w_sel_ok;
    logic [SELW-1:0]  w_sel_eff;
    logic [WIDTH-1:0] w_data;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < N) begin : g_used
                assign w_ch[gi] = D[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_ch[gi] = '0;
            end
        end
    endgenerate

    // Out-of-range manual selects keep the channel currently on the output.
    assign w_sel_ok  = ({1'b0, SEL_IN} < c_N_EXT);
    assign w_sel_eff = MODE ? r_ptr : (w_sel_ok ? SEL_IN : r_ch);
    assign w_data    = w_ch[w_sel_eff];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (!EN) begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_y     <= w_data;
            r_ch    <= w_sel_eff;
            r_valid <= 1'b1;
            if (MODE) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt <= '0;
                    if (r_ptr == c_LAST) begin
                        r_ptr  <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_ptr  <= r_ptr + SELW'(1);
                        r_wrap <= 1'b0;
                    end
                end else begin
                    r_cnt  <= r_cnt + CNTW'(1);
                    r_wrap <= 1'b0;
                end
            end else begin
                // Manual cycles seed the scanner so a later switch to auto
                // starts on this channel with a full dwell.
                r_ptr  <= w_sel_eff;
                r_cnt  <= '0;
                r_wrap <= 1'b0;
            end
        end
    end

    assign Y     = r_y;
    assign CH    = r_ch;
    assign VALID = r_valid;
    assign WRAP  = r_wrap;

endmodule

`default_nettype wire
